// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter_pkg
//  Description : Shared types and constants for the data-memory arbiter.
//                Holds the arbiter state encoding and the requester index
//                constants used to address the req/we/gnt/rvalid vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_arbiter_pkg;

    // Arbiter FSM states, explicitly 2 bits wide.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_e;

    // Bit positions of each requester in the per-requester vectors.
    localparam int REQ_CPU    = 0;
    localparam int REQ_LOADER = 1;

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Two-way round-robin winner selection (purely combinational).
//                A lone requester always wins; on a tie the requester that was
//                not granted last wins.
//  Ports       : req[1:0]    - request vector (bit 0 CPU, bit 1 loader)
//                last_grant  - index of the requester granted most recently
//                winner[1:0] - one-hot winner, 0 when nobody requests
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] winner
);

    always_comb begin
        winner = req;
        if (req[REQ_CPU] && req[REQ_LOADER]) begin
            // last_grant == 1 means the loader went last, so the CPU goes now.
            winner[REQ_CPU]    = last_grant;
            winner[REQ_LOADER] = ~last_grant;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Arbitrates a single data-memory port between the CPU
//                (requester 0) and the loader (requester 1). One transaction
//                is in flight at a time: IDLE -> ACCESS -> IDLE for stores,
//                IDLE -> ACCESS -> WAIT -> RESP -> IDLE for loads.
//  Parameters  : READ_LATENCY - cycles from address to valid dmem_data_out (1..3)
//  Ports       : clk, reset            - clock, synchronous active-high reset
//                req/we[1:0]           - per-requester request / store flag
//                addr*/wdata*/funct3_* - per-requester payload
//                gnt, rvalid [1:0]     - one-hot grant / read-valid pulses
//                rdata, busy           - shared read data, transaction active
//                dmem_*                - memory-side port
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [1:0]  we,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    input  logic [2:0]  funct3_0,
    input  logic [2:0]  funct3_1,
    output logic [1:0]  gnt,
    output logic [1:0]  rvalid,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        dmem_wren,
    output logic [31:0] dmem_address,
    output logic [31:0] dmem_data_in,
    output logic [2:0]  dmem_funct3,
    input  logic [31:0] dmem_data_out
);

    import dmem_arbiter_pkg::*;

    // WAIT ends on the cycle where the counter reaches this value; that cycle
    // is ACCESS + READ_LATENCY, when memory data is valid.
    localparam logic [1:0] C_LAST_WAIT = 2'(READ_LATENCY - 1);

    state_e      r_state;
    logic [1:0]  r_win;
    logic        r_last_grant;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_funct3;
    logic [1:0]  r_cnt;
    logic [31:0] r_rdata;

    logic [1:0]  w_winner;
    logic        w_idle;
    logic        w_access;

    rr_arbiter u_rr_arbiter (
        .req        (req),
        .last_grant (r_last_grant),
        .winner     (w_winner)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_cnt        <= 2'd0;
            r_rdata      <= 32'd0;
            r_win        <= 2'b00;
            r_we         <= 1'b0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_funct3     <= 3'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|req) begin
                        // Latch the winner's payload so requesters may drop
                        // or change their inputs from the grant cycle on.
                        r_win    <= w_winner;
                        r_we     <= w_winner[REQ_LOADER] ? we[REQ_LOADER] : we[REQ_CPU];
                        r_addr   <= w_winner[REQ_LOADER] ? addr1    : addr0;
                        r_wdata  <= w_winner[REQ_LOADER] ? wdata1   : wdata0;
                        r_funct3 <= w_winner[REQ_LOADER] ? funct3_1 : funct3_0;
                        r_state  <= ACCESS;
                    end
                end
                ACCESS: begin
                    r_last_grant <= r_win[REQ_LOADER];
                    r_cnt        <= 2'd0;
                    r_state      <= r_we ? IDLE : WAIT;
                end
                WAIT: begin
                    if (r_cnt == C_LAST_WAIT) begin
                        r_rdata <= dmem_data_out;
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign w_idle   = (r_state == IDLE);
    assign w_access = (r_state == ACCESS);

    assign gnt          = w_access ? r_win : 2'b00;
    assign rvalid       = (r_state == RESP) ? r_win : 2'b00;
    assign busy         = ~w_idle;
    assign rdata        = r_rdata;

    // Address is held from ACCESS through RESP; the bus is zeroed when idle.
    assign dmem_wren    = w_access & r_we;
    assign dmem_address = w_idle ? 32'd0 : r_addr;
    assign dmem_data_in = w_idle ? 32'd0 : r_wdata;
    assign dmem_funct3  = w_idle ? 3'd0  : r_funct3;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Self-checking bench for dmem_arbiter. Two instances are used,
//                READ_LATENCY=1 (index 0) and READ_LATENCY=3 (index 1), each
//                with its own requesters and behavioural memory. A
//                transaction-level model predicts every output every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int N_DUT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus (arrays are written only by the main initial process)
    logic        rst    [N_DUT];
    logic [1:0]  req    [N_DUT];
    logic [1:0]  we     [N_DUT];
    logic [31:0] addr0  [N_DUT];
    logic [31:0] addr1  [N_DUT];
    logic [31:0] wdata0 [N_DUT];
    logic [31:0] wdata1 [N_DUT];
    logic [2:0]  f3_0   [N_DUT];
    logic [2:0]  f3_1   [N_DUT];
    logic [31:0] dout   [N_DUT];

    // Observed outputs, one set per instance
    logic [1:0]  gnt_1, rvalid_1, gnt_3, rvalid_3;
    logic [31:0] rdata_1, daddr_1, ddin_1, rdata_3, daddr_3, ddin_3;
    logic        busy_1, wren_1, busy_3, wren_3;
    logic [2:0]  df3_1, df3_3;

    dmem_arbiter #(.READ_LATENCY(1)) u_dut_l1 (
        .clk(clk), .reset(rst[0]), .req(req[0]), .we(we[0]),
        .addr0(addr0[0]), .addr1(addr1[0]), .wdata0(wdata0[0]), .wdata1(wdata1[0]),
        .funct3_0(f3_0[0]), .funct3_1(f3_1[0]),
        .gnt(gnt_1), .rvalid(rvalid_1), .rdata(rdata_1), .busy(busy_1),
        .dmem_wren(wren_1), .dmem_address(daddr_1), .dmem_data_in(ddin_1),
        .dmem_funct3(df3_1), .dmem_data_out(dout[0])
    );

    dmem_arbiter #(.READ_LATENCY(3)) u_dut_l3 (
        .clk(clk), .reset(rst[1]), .req(req[1]), .we(we[1]),
        .addr0(addr0[1]), .addr1(addr1[1]), .wdata0(wdata0[1]), .wdata1(wdata1[1]),
        .funct3_0(f3_0[1]), .funct3_1(f3_1[1]),
        .gnt(gnt_3), .rvalid(rvalid_3), .rdata(rdata_3), .busy(busy_3),
        .dmem_wren(wren_3), .dmem_address(daddr_3), .dmem_data_in(ddin_3),
        .dmem_funct3(df3_3), .dmem_data_out(dout[1])
    );

    // ---------------- bench state ----------------
    int          n_tests, n_fail, t, gen_mode;
    int          RL [N_DUT] = '{1, 3};
    bit          rst_drv [N_DUT];
    // pending requests per instance / requester
    bit          pend  [N_DUT][2];
    bit          p_we  [N_DUT][2];
    logic [31:0] p_addr[N_DUT][2];
    logic [31:0] p_wd  [N_DUT][2];
    logic [2:0]  p_f3  [N_DUT][2];
    // transaction-level reference model
    bit          act     [N_DUT];
    bit          act_we  [N_DUT];
    int          act_g   [N_DUT];
    int          act_win [N_DUT];
    int          lastw   [N_DUT];
    int          free_e  [N_DUT];
    logic [31:0] act_addr[N_DUT];
    logic [31:0] act_wd  [N_DUT];
    logic [2:0]  act_f3  [N_DUT];
    logic [31:0] exp_rd  [N_DUT];
    logic [31:0] m_rdata [N_DUT];
    // behavioural memory device
    int          dev_rd  [N_DUT];
    logic [31:0] dev_a   [N_DUT];
    logic [31:0] mem [logic [32:0]];
    int          grant_log [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d: got %h expected %h", tag, t, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input int d, input logic [31:0] a);
        logic [32:0] k;
        k = {d[0], a};
        if (mem.exists(k)) return mem[k];
        if (a == 32'h100) return 32'hDEADBEEF;
        return a ^ 32'hC0DE_5A00;
    endfunction

    task automatic set_req(input int d, input int r, input bit w, input logic [31:0] a,
                           input logic [31:0] wd, input logic [2:0] f);
        pend[d][r]   = 1'b1;
        p_we[d][r]   = w;
        p_addr[d][r] = a;
        p_wd[d][r]   = wd;
        p_f3[d][r]   = f;
    endtask

    task automatic new_req(input int d, input int r);
        set_req(d, r, 1'($urandom_range(0, 1)), 32'h400 + (32'($urandom_range(0, 15)) << 2),
                $urandom, 3'($urandom_range(0, 7)));
    endtask

    task automatic drive();
        for (int d = 0; d < N_DUT; d++) begin
            rst[d]    = rst_drv[d];
            req[d]    = {pend[d][1], pend[d][0]};
            we[d]     = {p_we[d][1], p_we[d][0]};
            addr0[d]  = p_addr[d][0];
            addr1[d]  = p_addr[d][1];
            wdata0[d] = p_wd[d][0];
            wdata1[d] = p_wd[d][1];
            f3_0[d]   = p_f3[d][0];
            f3_1[d]   = p_f3[d][1];
        end
    endtask

    // Advance one clock, predict and check all outputs of both instances,
    // run the memory devices and generate new requests.
    task automatic step();
        @(posedge clk);
        #1;
        t++;
        for (int d = 0; d < N_DUT; d++) begin
            logic [1:0]  o_gnt, o_rv, e_gnt, e_rv;
            logic [31:0] o_rd, o_addr, o_din, e_addr, e_din;
            logic [2:0]  o_f3, e_f3;
            logic        o_busy, o_wren, e_busy, e_wren;
            bit          ck_addr, ck_data;
            string       pfx;
            if (d == 0) begin
                o_gnt = gnt_1; o_rv = rvalid_1; o_rd = rdata_1; o_busy = busy_1;
                o_wren = wren_1; o_addr = daddr_1; o_din = ddin_1; o_f3 = df3_1;
            end else begin
                o_gnt = gnt_3; o_rv = rvalid_3; o_rd = rdata_3; o_busy = busy_3;
                o_wren = wren_3; o_addr = daddr_3; o_din = ddin_3; o_f3 = df3_3;
            end
            pfx = $sformatf("L%0d", RL[d]);
            e_gnt = 2'b00; e_rv = 2'b00; e_busy = 1'b0; e_wren = 1'b0;
            e_addr = 32'd0; e_din = 32'd0; e_f3 = 3'd0;
            ck_addr = 1'b1; ck_data = 1'b1;

            // Arbitration decision made at this edge
            if (rst_drv[d]) begin
                act[d] = 1'b0; lastw[d] = 1; m_rdata[d] = 32'd0; free_e[d] = t + 1;
            end else if (!act[d] && t >= free_e[d] && (pend[d][0] || pend[d][1])) begin
                int w;
                if (pend[d][0] && pend[d][1]) w = 1 - lastw[d];
                else                          w = pend[d][0] ? 0 : 1;
                act[d] = 1'b1; act_g[d] = t; act_win[d] = w; lastw[d] = w;
                act_we[d] = p_we[d][w]; act_addr[d] = p_addr[d][w];
                act_wd[d] = p_wd[d][w]; act_f3[d] = p_f3[d][w];
                pend[d][w] = 1'b0;
                if (d == 0) grant_log.push_back(w);
                if (gen_mode == 1) new_req(d, w);
            end

            // Expected outputs for this cycle
            if (act[d]) begin
                e_busy = 1'b1;
                if (t == act_g[d]) begin
                    e_gnt = 2'(1 << act_win[d]); e_wren = act_we[d];
                    e_addr = act_addr[d]; e_din = act_wd[d]; e_f3 = act_f3[d];
                    if (act_we[d]) begin
                        act[d] = 1'b0; free_e[d] = t + 2;
                    end else begin
                        exp_rd[d] = mem_rd(d, act_addr[d]);
                    end
                end else if (t <= act_g[d] + RL[d]) begin
                    e_addr = act_addr[d]; ck_data = 1'b0;
                end else begin
                    e_rv = 2'(1 << act_win[d]); m_rdata[d] = exp_rd[d];
                    ck_addr = 1'b0; ck_data = 1'b0;
                    act[d] = 1'b0; free_e[d] = t + 2;
                end
            end

            chk({pfx, ".gnt"},    32'(o_gnt),  32'(e_gnt));
            chk({pfx, ".rvalid"}, 32'(o_rv),   32'(e_rv));
            chk({pfx, ".busy"},   32'(o_busy), 32'(e_busy));
            chk({pfx, ".wren"},   32'(o_wren), 32'(e_wren));
            chk({pfx, ".rdata"},  o_rd,        m_rdata[d]);
            if (ck_addr) chk({pfx, ".address"}, o_addr, e_addr);
            if (ck_data) begin
                chk({pfx, ".data_in"}, o_din, e_din);
                chk({pfx, ".funct3"},  32'(o_f3), 32'(e_f3));
            end

            // Memory device: data valid only READ_LATENCY cycles after a read grant
            if (rst_drv[d]) begin
                dev_rd[d] = -1;
            end else begin
                if (o_wren === 1'b1) mem[{d[0], o_addr}] = o_din;
                if (o_gnt != 2'b00 && o_wren !== 1'b1) begin
                    dev_rd[d] = t + RL[d]; dev_a[d] = o_addr;
                end
            end
            dout[d] = (t == dev_rd[d]) ? mem_rd(d, dev_a[d]) : $urandom;

            if (gen_mode == 2 && !rst_drv[d]) begin
                for (int r = 0; r < 2; r++)
                    if (!pend[d][r] && $urandom_range(0, 3) == 0) new_req(d, r);
            end
        end
        drive();
    endtask

    task automatic do_reset(input int d);
        rst_drv[d] = 1'b1;
        pend[d][0] = 1'b0;
        pend[d][1] = 1'b0;
        drive();
        step();
        step();
        rst_drv[d] = 1'b0;
        drive();
    endtask

    initial begin
        n_tests = 0; n_fail = 0; t = 0; gen_mode = 0;
        for (int d = 0; d < N_DUT; d++) begin
            rst_drv[d] = 1'b1; act[d] = 1'b0; lastw[d] = 1; free_e[d] = 0;
            dev_rd[d] = -1; dev_a[d] = 32'd0; m_rdata[d] = 32'd0; exp_rd[d] = 32'd0;
            dout[d] = 32'd0;
            for (int r = 0; r < 2; r++) begin
                pend[d][r] = 1'b0; p_we[d][r] = 1'b0; p_addr[d][r] = 32'd0;
                p_wd[d][r] = 32'd0; p_f3[d][r] = 3'd0;
            end
        end
        drive();
        step();
        step();
        rst_drv[0] = 1'b0;
        rst_drv[1] = 1'b0;
        drive();

        // CPU read of 0x100 (memory holds 0xDEADBEEF), latency 1
        set_req(0, 0, 1'b0, 32'h100, 32'h0, 3'b010);
        drive();
        repeat (6) step();

        // Loader store 0x12345678 to 0x200, funct3 010
        set_req(0, 1, 1'b1, 32'h200, 32'h1234_5678, 3'b010);
        drive();
        repeat (4) step();

        // Both requesters held high for four transactions after reset
        do_reset(0);
        grant_log.delete();
        gen_mode = 1;
        new_req(0, 0);
        new_req(0, 1);
        drive();
        repeat (20) step();
        gen_mode = 0;
        pend[0][0] = 1'b0;
        pend[0][1] = 1'b0;
        drive();
        repeat (8) step();
        for (int i = 0; i < 4; i++)
            chk($sformatf("rr_order[%0d]", i),
                (i < grant_log.size()) ? 32'(grant_log[i]) : 32'hFFFF_FFFF, 32'(i % 2));

        // Latency 3 read of 0x300
        set_req(1, 0, 1'b0, 32'h300, 32'h0, 3'b000);
        drive();
        repeat (8) step();

        // Reset during WAIT aborts the read; a fresh CPU read then completes
        set_req(1, 0, 1'b0, 32'h304, 32'h0, 3'b010);
        drive();
        step();
        step();
        rst_drv[1] = 1'b1;
        drive();
        step();
        rst_drv[1] = 1'b0;
        drive();
        repeat (2) step();
        set_req(1, 0, 1'b0, 32'h308, 32'h0, 3'b100);
        drive();
        repeat (8) step();

        // Random traffic on both instances, requests arriving while busy
        gen_mode = 2;
        repeat (3000) step();
        gen_mode = 0;
        repeat (40) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter READ_LATENCY, default 1, the number of cycles from address presentation to valid dmem_data_out; legal range 1..3.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port req  input  2  per-requester access request; bit 0 = CPU, bit 1 = loader.
REQ-005 SHALL have port we  input  2  per-requester write flag (1 = store, 0 = load).
REQ-006 SHALL have ports addr0, addr1  input  32 each  per-requester byte address.
REQ-007 SHALL have ports wdata0, wdata1  input  32 each  per-requester store data.
REQ-008 SHALL have ports funct3_0, funct3_1  input  3 each  per-requester access size/sign code, passed to memory unchanged.
REQ-009 SHALL have port gnt  output  2  one-hot grant pulse.
REQ-010 SHALL have port rvalid  output  2  one-hot read-data-valid pulse.
REQ-011 SHALL have port rdata  output  32  read data shared by both requesters.
REQ-012 SHALL have port busy  output  1  high whenever a transaction is in progress.
REQ-013 SHALL have ports dmem_wren  output  1, dmem_address  output  32, dmem_data_in  output  32, dmem_funct3  output  3, and dmem_data_out  input  32; these form the memory-side port.

Function
REQ-014 SHALL implement states IDLE, ACCESS, WAIT and RESP, with at most one transaction outstanding at any time.
REQ-015 IDLE: when any req bit is high at a clock edge, SHALL latch the winner's we, addr, wdata and funct3, and move to ACCESS.
REQ-016 Arbitration SHALL be round-robin over a last_grant register: if both requesters are asking, the one not granted last wins; a lone requester always wins.
REQ-017 ACCESS lasts one cycle: gnt[winner]=1; dmem_address, dmem_data_in and dmem_funct3 come from the latched values; dmem_wren equals the latched we; last_grant is updated.
REQ-018 Write path: ACCESS -> IDLE, so dmem_wren is high for exactly one cycle.
REQ-019 Read path: ACCESS -> WAIT; WAIT counts READ_LATENCY-1 further cycles (zero cycles when READ_LATENCY=1); dmem_address is held stable and dmem_wren=0 throughout.
REQ-020 The read sample cycle is ACCESS+READ_LATENCY; at the end of that cycle dmem_data_out SHALL be registered into rdata, then the FSM moves to RESP.
REQ-021 RESP lasts one cycle, with rvalid[winner]=1 and rdata valid; then RESP -> IDLE.
REQ-022 Read timing: req seen at edge N gives gnt in cycle N+1 and rvalid in cycle N+2+READ_LATENCY. Write timing: req seen at edge N gives gnt and dmem_wren in cycle N+1.
REQ-023 The earliest next grant SHALL be two cycles after the previous RESP or write ACCESS cycle (IDLE re-samples req).
REQ-024 Requester rule: req and its payload are held stable until gnt; req is dropped in the gnt cycle or re-asserted for a new access. The arbiter SHALL ignore requests outside IDLE.
REQ-025 In IDLE, dmem_wren=0 and dmem_address, dmem_data_in and dmem_funct3 are 0; gnt and rvalid are 0 in every state except ACCESS and RESP respectively.
REQ-026 rdata SHALL hold its last captured value outside RESP.
REQ-027 busy SHALL be 1 in ACCESS, WAIT and RESP, and 0 in IDLE.

Reset
REQ-028 On reset: state=IDLE, last_grant=1 (CPU wins the first tie), latency counter=0, rdata=0, and gnt, rvalid, busy and dmem_wren all 0.
REQ-029 Reset asserted mid-transaction SHALL abort it: no rvalid issued, no further dmem_wren, and the FSM is IDLE on the cycle after reset.

Structure
REQ-030 A shared package SHALL hold the state enum (IDLE, ACCESS, WAIT, RESP) and the requester index constants REQ_CPU=0 and REQ_LOADER=1.
REQ-031 Winner selection SHALL live in a combinational sub-module rr_arbiter (inputs: req[1:0], last_grant; output: one-hot winner).

Verification
REQ-032 Bench SHALL cover a CPU read with req=01, we=0, addr0=0x100, READ_LATENCY=1 and memory returning 0xDEADBEEF: gnt=01 one cycle after req, then rvalid=01 with rdata=0xDEADBEEF two cycles later.
REQ-033 Bench SHALL cover a loader write with req=10, we=10, addr1=0x200, wdata1=0x12345678, funct3_1=010: gnt=10 and dmem_wren=1 with exactly those values for one cycle, and rvalid never asserted.
REQ-034 Bench SHALL cover contention with req=11 held for 4 transactions after reset: grant order CPU, loader, CPU, loader.
REQ-035 Bench SHALL cover READ_LATENCY=3 with a read to 0x300: dmem_address stays 0x300 for 3 cycles, and rvalid occurs 5 cycles after req is sampled.
REQ-036 Bench SHALL cover reset asserted during WAIT: no rvalid, busy=0 and state IDLE the next cycle; a new req=01 is then granted normally.
REQ-037 Bench SHALL cover req changes while busy: requests are ignored until IDLE, and dmem_address never changes mid-transaction.
